lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- Load/store initiator between the core's memory stage and the word-organised data memory.
- The data memory has one combinational read port and one synchronous write port with a write enable.
- Accepts one RV32I load or store per handshake, sign- or zero-extends sub-word loads, and performs read-modify-write for SB/SH.
- Flags misaligned, out-of-range and illegal-funct3 requests without touching memory.

Parameters:
- ADDR_W, 7, byte-address width of data memory (2^ADDR_W bytes; default 32 words).
- XLEN, 32, data width; fixed at 32, any other value unsupported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  block can accept request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bytes used for SB/SH)
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request rejected, no memory access
- mem_addr  out  ADDR_W-2  word address to data memory
- mem_we  out  1  data memory write enable
- mem_wd  out  32  data memory write data
- mem_rd  in  32  data memory read data (combinational from mem_addr)

Behaviour:
- States: IDLE, ACCESS, MERGE, RESP (2-bit state register).
- Reset (reset=0, asynchronous):
  - state=IDLE; all request/merge/response registers cleared.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_addr=0, mem_we=0, mem_wd=0.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at a clock edge, latch we, funct3, addr and wdata.
  - If the request is illegal, go to RESP with err=1 and no memory access.
  - Otherwise go to ACCESS.
- Illegal request, any of:
  - funct3 in {011, 110, 111};
  - store with funct3 100/101;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:ADDR_W]!=0.
- mem_addr is registered and updates only on acceptance: addr[ADDR_W-1:2].
- ACCESS, load:
  - Byte select by addr[1:0], halfword by addr[1].
  - Sign-extend for 000/001, zero-extend for 100/101.
  - Capture the extended value into resp_rdata, then go to RESP.
- ACCESS, SW:
  - mem_we=1 for this cycle only, mem_wd=wdata; go to RESP.
- ACCESS, SB/SH:
  - Capture mem_rd into the merge register; go to MERGE.
  - mem_we=0.
- MERGE:
  - mem_we=1; mem_wd = merge register with the selected byte/halfword lanes replaced by wdata[7:0] or wdata[15:0].
  - Other lanes unchanged. Go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable.
  - When resp_ready=1 at an edge, go to IDLE and clear resp_valid/resp_err.
  - req_ready=0 in every non-IDLE state (no pipelining; at most one outstanding).
- mem_we is 1 only in ACCESS (SW) and MERGE (SB/SH).
- mem_wd is 0 whenever mem_we=0.
- Latency from acceptance edge to resp_valid high:
  - 2 cycles for loads and SW;
  - 3 cycles for SB/SH;
  - 1 cycle for errors.
- A response can be accepted in its first valid cycle; back-to-back throughput is then one request per 3/4 cycles.
- Reset asserted in any state:
  - abort immediately; mem_we drops asynchronously;
  - no partial write occurs after reset deasserts; the pending response is discarded.
- Address wrap: the highest word (addr 2^ADDR_W-4) is legal; addr 2^ADDR_W is out-of-range (err), never aliased to word 0.

Test Plan:
- Reset with reset=0 mid-MERGE (mem_we=1) -> mem_we=0 within the same cycle; after release, state IDLE, req_ready=1; memory word unchanged from its pre-store value.
- SW addr=0x08 wdata=0xDEADBEEF, then LW 0x08 -> mem_addr=2, mem_we pulses 1 cycle; load resp_rdata=0xDEADBEEF, resp_valid 2 cycles after acceptance.
- Word 0x08=0x11223344; SB addr=0x09 wdata=0xAA -> one read then one write, mem_wd=0x1122AA44; LB 0x09 -> 0xFFFFFFAA; LBU 0x09 -> 0x000000AA.
- SH addr=0x0E wdata=0x8001 onto word 0x0C=0 -> mem_wd=0x80010000; LH 0x0E -> 0xFFFF8001; LHU -> 0x00008001.
- LW addr=0x06, LH addr=0x03, SW addr=0x80, funct3=011 -> each resp_err=1 after 1 cycle, resp_rdata=0, mem_we never asserted.
- Hold resp_ready=0 for 5 cycles after LW -> resp_valid and resp_rdata stable, req_ready=0, a new req_valid is ignored; resp_ready=1 -> IDLE next cycle.

Source files
------------

// File: rtl/lsu_mem_initiator_if.sv
// Core-side request/response handshake plus data-memory port for the LSU initiator.
interface lsu_mem_initiator_if #(
  parameter int ADDR_W = 7
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;

  // Initiator view
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wd
  );

  // Core + memory view
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wd
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// RV32I load/store initiator: one outstanding request, sub-word load extension,
// read-modify-write for SB/SH, and early rejection of illegal requests.
module lsu_mem_initiator #(
  parameter int ADDR_W = 7,
  parameter int XLEN   = 32
) (
  input logic clk,
  input logic reset,
  lsu_mem_initiator_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] MERGE  = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]        state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   merge_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;
  logic [ADDR_W-3:0] maddr_q;

  logic              illegal;
  logic [XLEN-1:0]   load_ext;
  logic [XLEN-1:0]   merged;
  logic              wr_en;

  // Reject bad funct3, sub-word/unsigned stores, misalignment and any address past the memory
  always_comb begin
    illegal = 1'b0;
    if (bus.req_funct3 inside {3'b011, 3'b110, 3'b111})            illegal = 1'b1;
    if (bus.req_we && bus.req_funct3[2])                           illegal = 1'b1;
    if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])           illegal = 1'b1;
    if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b0) illegal = 1'b1;
    if ((bus.req_addr >> ADDR_W) != 32'd0)                         illegal = 1'b1;
  end

  // Lane-select and extend the combinational read word for loads
  always_comb begin
    logic [7:0]  lb;
    logic [15:0] lh;
    lb = bus.mem_rd[{off_q, 3'b000} +: 8];
    lh = off_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{lb[7]}}, lb};
      3'b001:  load_ext = {{16{lh[15]}}, lh};
      3'b100:  load_ext = {24'd0, lb};
      3'b101:  load_ext = {16'd0, lh};
      default: load_ext = bus.mem_rd;
    endcase
  end

  // Splice the store byte/halfword into the word captured during ACCESS
  always_comb begin
    merged = merge_q;
    if (f3_q[0]) begin
      if (off_q[1]) merged[31:16] = wdata_q[15:0];
      else          merged[15:0]  = wdata_q[15:0];
    end else begin
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Write strobe decoded from state so reset kills it without waiting for a clock
  assign wr_en = (state == ACCESS && we_q && f3_q == 3'b010) || (state == MERGE);

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_we     = wr_en;
  assign bus.mem_wd     = !wr_en ? '0 : (state == MERGE ? merged : wdata_q);

  // Request sequencing: accept, access/merge, then hold the response until taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      off_q   <= 2'b0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      maddr_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          we_q    <= bus.req_we;
          f3_q    <= bus.req_funct3;
          off_q   <= bus.req_addr[1:0];
          wdata_q <= bus.req_wdata;
          maddr_q <= bus.req_addr[ADDR_W-1:2];
          rdata_q <= '0;
          err_q   <= illegal;
          state   <= illegal ? RESP : ACCESS;
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= load_ext;
            state   <= RESP;
          end else if (f3_q == 3'b010) begin
            state   <= RESP;
          end else begin
            merge_q <= bus.mem_rd;
            state   <= MERGE;
          end
        end
        MERGE: state <= RESP;
        RESP: if (bus.resp_ready) begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a behavioural word memory.
module tb_lsu_mem_initiator;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_initiator_if #(.ADDR_W(7)) bus ();

  lsu_mem_initiator #(.ADDR_W(7), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:31];
  assign bus.mem_rd = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wd;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
    logic [31:0] wd;
  } vec_t;

  function automatic vec_t mk(input string name, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input int lat,
                              input int writes, input logic [31:0] wd);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.lat = lat; v.writes = writes; v.wd = wd;
    return v;
  endfunction

  // Issue one request at a negedge, track it to the response, and check everything seen
  task automatic run(input vec_t v);
    int n, wr;
    logic [31:0] wd;
    logic [4:0] ma;
    logic wdz_ok, rdy_ok;
    bus.req_we = v.we; bus.req_funct3 = v.f3; bus.req_addr = v.addr; bus.req_wdata = v.wdata;
    bus.req_valid = 1'b1;
    chk({v.name, ".req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1 bus.req_valid = 1'b0;
    n = 0; wr = 0; wd = '0; wdz_ok = 1'b1; rdy_ok = 1'b1; ma = '0;
    while (n < 8) begin
      @(negedge clk); n++;
      if (n == 1) ma = bus.mem_addr;
      if (bus.mem_we) begin wr++; wd = bus.mem_wd; end
      else if (bus.mem_wd !== 32'd0) wdz_ok = 1'b0;
      if (bus.req_ready) rdy_ok = 1'b0;
      if (bus.resp_valid) break;
    end
    chk({v.name, ".latency"}, n, v.lat);
    chk({v.name, ".rdata"}, bus.resp_rdata, v.rdata);
    chk({v.name, ".err"}, {31'd0, bus.resp_err}, {31'd0, v.err});
    chk({v.name, ".writes"}, wr, v.writes);
    if (v.writes > 0) chk({v.name, ".mem_wd"}, wd, v.wd);
    if (!v.err) chk({v.name, ".mem_addr"}, {27'd0, ma}, {27'd0, v.addr[6:2]});
    chk({v.name, ".wd_zero_idle"}, {31'd0, wdz_ok}, 32'd1);
    chk({v.name, ".busy_not_ready"}, {31'd0, rdy_ok}, 32'd1);
    @(posedge clk); #1;
    chk({v.name, ".back_idle"}, {30'd0, bus.req_ready, bus.resp_valid}, 32'd2);
    @(negedge clk);
  endtask

  vec_t vecs [22];

  initial begin
    vecs[0]  = mk("sw08",    1, 3'b010, 32'h08, 32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF);
    vecs[1]  = mk("lw08",    0, 3'b010, 32'h08, 32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0);
    vecs[2]  = mk("sw08b",   1, 3'b010, 32'h08, 32'h11223344, 32'h0,        0, 2, 1, 32'h11223344);
    vecs[3]  = mk("sb09",    1, 3'b000, 32'h09, 32'hFFFFFFAA, 32'h0,        0, 3, 1, 32'h1122AA44);
    vecs[4]  = mk("lb09",    0, 3'b000, 32'h09, 32'h0,        32'hFFFFFFAA, 0, 2, 0, 32'h0);
    vecs[5]  = mk("lbu09",   0, 3'b100, 32'h09, 32'h0,        32'h000000AA, 0, 2, 0, 32'h0);
    vecs[6]  = mk("sh0e",    1, 3'b001, 32'h0E, 32'h00008001, 32'h0,        0, 3, 1, 32'h80010000);
    vecs[7]  = mk("lh0e",    0, 3'b001, 32'h0E, 32'h0,        32'hFFFF8001, 0, 2, 0, 32'h0);
    vecs[8]  = mk("lhu0e",   0, 3'b101, 32'h0E, 32'h0,        32'h00008001, 0, 2, 0, 32'h0);
    vecs[9]  = mk("lw06",    0, 3'b010, 32'h06, 32'h0,        32'h0,        1, 1, 0, 32'h0);
    vecs[10] = mk("lh03",    0, 3'b001, 32'h03, 32'h0,        32'h0,        1, 1, 0, 32'h0);
    vecs[11] = mk("sw80",    1, 3'b010, 32'h80, 32'h55555555, 32'h0,        1, 1, 0, 32'h0);
    vecs[12] = mk("f3_011",  0, 3'b011, 32'h00, 32'h0,        32'h0,        1, 1, 0, 32'h0);
    vecs[13] = mk("st_f3hu", 1, 3'b101, 32'h0C, 32'h1234,     32'h0,        1, 1, 0, 32'h0);
    vecs[14] = mk("sw7c",    1, 3'b010, 32'h7C, 32'h12345678, 32'h0,        0, 2, 1, 32'h12345678);
    vecs[15] = mk("lw7c",    0, 3'b010, 32'h7C, 32'h0,        32'h12345678, 0, 2, 0, 32'h0);
    vecs[16] = mk("lb7f",    0, 3'b000, 32'h7F, 32'h0,        32'h00000012, 0, 2, 0, 32'h0);
    vecs[17] = mk("lh7e",    0, 3'b001, 32'h7E, 32'h0,        32'h00001234, 0, 2, 0, 32'h0);
    vecs[18] = mk("sb0b",    1, 3'b000, 32'h0B, 32'h00000080, 32'h0,        0, 3, 1, 32'h8022AA44);
    vecs[19] = mk("lb0b",    0, 3'b000, 32'h0B, 32'h0,        32'hFFFFFF80, 0, 2, 0, 32'h0);
    vecs[20] = mk("sh0c",    1, 3'b001, 32'h0C, 32'h00007FFF, 32'h0,        0, 3, 1, 32'h80017FFF);
    vecs[21] = mk("lh0c",    0, 3'b001, 32'h0C, 32'h0,        32'h00007FFF, 0, 2, 0, 32'h0);

    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[4] = 32'h0BADF00D;
    bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0;
    bus.req_wdata = 0; bus.resp_ready = 1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.req_ready",  {31'd0, bus.req_ready},  32'd1);
    chk("rst.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst.resp_rdata", bus.resp_rdata,          32'd0);
    chk("rst.resp_err",   {31'd0, bus.resp_err},   32'd0);
    chk("rst.mem_addr",   {27'd0, bus.mem_addr},   32'd0);
    chk("rst.mem_we",     {31'd0, bus.mem_we},     32'd0);
    chk("rst.mem_wd",     bus.mem_wd,              32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 22; i++) run(vecs[i]);
    chk("mem.word2", mem[2], 32'h8022AA44);
    chk("mem.word3", mem[3], 32'h80017FFF);

    // Stalled response: held stable, new request ignored
    bus.resp_ready = 1'b0;
    bus.req_we = 0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h08; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_we = 1; bus.req_addr = 32'h10; bus.req_wdata = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("hold.resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("hold.rdata",      bus.resp_rdata,          32'h8022AA44);
      chk("hold.req_ready",  {31'd0, bus.req_ready},  32'd0);
      chk("hold.mem_we",     {31'd0, bus.mem_we},     32'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold.release_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("hold.release_ready", {31'd0, bus.req_ready},  32'd1);
    chk("hold.mem4_intact",   mem[4],                  32'h0BADF00D);
    @(negedge clk);

    // Reset in MERGE: write strobe drops at once and the word keeps its old value
    bus.req_we = 1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h08; bus.req_wdata = 32'h55;
    bus.req_valid = 1'b1;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rmw.merge_we", {31'd0, bus.mem_we}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rmw.rst_we",        {31'd0, bus.mem_we},     32'd0);
    chk("rmw.rst_wd",        bus.mem_wd,              32'd0);
    chk("rmw.rst_req_ready", {31'd0, bus.req_ready},  32'd1);
    chk("rmw.rst_valid",     {31'd0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rmw.word_intact", mem[2], 32'h8022AA44);
    chk("rmw.post_ready",  {31'd0, bus.req_ready}, 32'd1);
    run(mk("lw08_post", 0, 3'b010, 32'h08, 32'h0, 32'h8022AA44, 0, 2, 0, 32'h0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
